// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 one-wire strip paths (driver and decoder):
// decoder state encoding, default bit timing and the channel width.
package ws2812_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_e;

  // Default bit timing in clk cycles (50 MHz): one bit period, high times for 0 and 1.
  localparam int TOTAL_PULSE_TIME = 70;
  localparam int ZERO_HIGH_TIME   = 20;
  localparam int ONE_HIGH_TIME    = 50;
  localparam int THRESHOLD_TIME   = 35;
  localparam int RESET_TIME       = 2500;
  localparam int CHANNEL_WIDTH    = 8;

  // Saturating 16-bit increment used for the per-frame byte index.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ws2812_decoder_sync_edge_detect.sv
// Two-flop synchronizer for the asynchronous strip input, followed by a
// registered copy and registered single-cycle rise/fall pulses. level_o is
// the registered copy, so it is aligned with the edge pulses.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic rise_q;
  logic fall_q;

  // Synchronize the pin and register edge pulses against the previous level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
      fall_q <= ~sync_q & prev_q;
    end
  end

  assign level_o = prev_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ws2812_decoder.sv
// WS2812 one-wire stream decoder: classifies high pulses into bits, packs
// MSB-first bytes into a BRAM write port and reports per-frame status.
// Optional feature macro: WS2812_DECODER_GLITCH_FILTER_EN rejects high pulses
// shorter than GLITCH_TIME (no bit, error set, low run keeps counting).
module ws2812_decoder #(
  parameter int ADDRESS_WIDTH  = 13,
  parameter int MAX_BYTES      = 480,
  parameter int THRESHOLD_TIME = ws2812_pkg::THRESHOLD_TIME,
  parameter int MAX_HIGH_TIME  = 100,
  parameter int RESET_TIME     = ws2812_pkg::RESET_TIME,
  parameter int GLITCH_TIME    = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     din,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [7:0]               mem_din,
  output logic                     frame_done,
  output logic [15:0]              byte_count,
  output logic                     error,
  output logic                     overflow
);
  import ws2812_pkg::*;

  localparam int CNT_W = $clog2(RESET_TIME + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] THR_C    = CNT_W'(THRESHOLD_TIME);
  localparam logic [CNT_W-1:0] MAXH_C   = CNT_W'(MAX_HIGH_TIME);
  localparam logic [CNT_W-1:0] RST_C    = CNT_W'(RESET_TIME);
  localparam logic [CNT_W-1:0] GLITCH_C = CNT_W'(GLITCH_TIME);
  localparam logic [15:0]      MAXB_C   = 16'(MAX_BYTES);
  localparam logic [2:0]       LAST_BIT = 3'(CHANNEL_WIDTH - 1);

`ifdef WS2812_DECODER_GLITCH_FILTER_EN
  localparam logic GLITCH_EN = 1'b1;
`else
  localparam logic GLITCH_EN = 1'b0;
`endif

  logic level_s;
  logic rise_s;
  logic fall_s;

  sync_edge_detect u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (din),
    .level_o (level_s),
    .rise_o  (rise_s),
    .fall_o  (fall_s)
  );

  state_e                     state_q, state_d;
  logic [CNT_W-1:0]           high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0]           low_cnt_q, low_cnt_d;
  logic [2:0]                 bit_cnt_q, bit_cnt_d;
  logic [CHANNEL_WIDTH-2:0]   shift_q, shift_d;
  logic [15:0]                byte_idx_q, byte_idx_d;
  logic                       mem_we_q, mem_we_d;
  logic [ADDRESS_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]                 mem_din_q, mem_din_d;
  logic                       frame_done_q, frame_done_d;
  logic [15:0]                byte_count_q, byte_count_d;
  logic                       error_q, error_d;
  logic                       overflow_q, overflow_d;

  // The pulse width measured at the falling edge is the held count plus the
  // current cycle, so comparisons use the incremented value.
  logic [CNT_W-1:0]           high_inc_s;
  logic [CNT_W-1:0]           low_inc_s;
  logic                       bit_s;
  logic [7:0]                 byte_s;

  // Saturating counter increments and the bit/byte that a falling edge would complete.
  always_comb begin
    high_inc_s = (high_cnt_q == CNT_MAX) ? high_cnt_q : high_cnt_q + CNT_W'(1);
    low_inc_s  = (low_cnt_q == CNT_MAX) ? low_cnt_q : low_cnt_q + CNT_W'(1);
    bit_s      = (high_inc_s >= THR_C);
    byte_s     = {shift_q, bit_s};
  end

  // Decoder next-state logic: frame sync, pulse classification, byte writes, frame end.
  always_comb begin
    state_d      = state_q;
    high_cnt_d   = high_cnt_q;
    low_cnt_d    = low_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_idx_d   = byte_idx_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    frame_done_d = 1'b0;
    byte_count_d = byte_count_q;
    error_d      = error_q;
    overflow_d   = overflow_q;

    case (state_q)
      SYNC: begin
        // Only a full reset-length low run proves we are between frames.
        if (level_s) begin
          low_cnt_d = '0;
        end else if (low_inc_s >= RST_C) begin
          low_cnt_d = '0;
          state_d   = IDLE;
        end else begin
          low_cnt_d = low_inc_s;
        end
      end

      IDLE: begin
        if (rise_s) begin
          bit_cnt_d  = 3'd0;
          byte_idx_d = 16'd0;
          error_d    = 1'b0;
          high_cnt_d = '0;
          low_cnt_d  = '0;
          state_d    = HIGH;
        end else begin
          state_d = IDLE;
        end
      end

      HIGH: begin
        high_cnt_d = high_inc_s;
        // With the glitch filter the low run keeps counting through a high
        // pulse, so a rejected spike leaves the low count as if it never happened.
        if (GLITCH_EN) begin
          low_cnt_d = low_inc_s;
        end else begin
          low_cnt_d = low_cnt_q;
        end

        if (high_inc_s > MAXH_C) begin
          error_d   = 1'b1;
          bit_cnt_d = 3'd0;
          shift_d   = '0;
          low_cnt_d = '0;
          state_d   = SYNC;
        end else if (fall_s) begin
          if (GLITCH_EN && (high_inc_s < GLITCH_C)) begin
            error_d = 1'b1;
            state_d = LOW;
          end else begin
            shift_d   = byte_s[CHANNEL_WIDTH-2:0];
            low_cnt_d = '0;
            state_d   = LOW;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_d  = 3'd0;
              byte_idx_d = sat_inc16(byte_idx_q);
              if (byte_idx_q < MAXB_C) begin
                mem_we_d   = 1'b1;
                mem_addr_d = ADDRESS_WIDTH'(byte_idx_q);
                mem_din_d  = byte_s;
              end else begin
                mem_we_d = 1'b0;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end else begin
          state_d = HIGH;
        end
      end

      LOW: begin
        low_cnt_d = low_inc_s;
        if (low_inc_s >= RST_C) begin
          // A frame ending mid-byte discards the partial byte and flags it.
          if (bit_cnt_q != 3'd0) begin
            error_d = 1'b1;
          end else begin
            error_d = error_q;
          end
          bit_cnt_d    = 3'd0;
          shift_d      = '0;
          low_cnt_d    = '0;
          frame_done_d = 1'b1;
          byte_count_d = byte_idx_q;
          overflow_d   = (byte_idx_q > MAXB_C);
          state_d      = IDLE;
        end else if (rise_s) begin
          high_cnt_d = '0;
          state_d    = HIGH;
        end else begin
          state_d = LOW;
        end
      end

      default: begin
        state_d = SYNC;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SYNC;
      high_cnt_q   <= '0;
      low_cnt_q    <= '0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= '0;
      byte_idx_q   <= 16'd0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= 8'd0;
      frame_done_q <= 1'b0;
      byte_count_q <= 16'd0;
      error_q      <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      high_cnt_q   <= high_cnt_d;
      low_cnt_q    <= low_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_idx_q   <= byte_idx_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      frame_done_q <= frame_done_d;
      byte_count_q <= byte_count_d;
      error_q      <= error_d;
      overflow_q   <= overflow_d;
    end
  end

  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign frame_done = frame_done_q;
  assign byte_count = byte_count_q;
  assign error      = error_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ws2812_decoder.sv
// Self-checking bench for ws2812_decoder. Expected memory writes and frame
// results are queued as stimulus is driven and compared when the DUT emits
// them. MAX_BYTES is reduced so the overflow frame stays short.
module tb_ws2812_decoder;
  import ws2812_pkg::*;

  localparam int AW   = 13;
  localparam int MAXB = 6;
  localparam int RT   = 2500;
  localparam int GAP  = RT + 100;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             din = 1'b0;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [7:0]       mem_din;
  logic             frame_done;
  logic [15:0]      byte_count;
  logic             error;
  logic             overflow;

  always #5 clk = ~clk;

  ws2812_decoder #(
    .ADDRESS_WIDTH (AW),
    .MAX_BYTES     (MAXB),
    .RESET_TIME    (RT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .frame_done (frame_done),
    .byte_count (byte_count),
    .error      (error),
    .overflow   (overflow)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  typedef struct packed {
    logic [15:0] cnt;
    logic        err;
    logic        ovf;
  } fr_t;

  wr_t wq[$];
  fr_t fq[$];
  wr_t mon_w;
  fr_t mon_f;
  int  errors = 0;
  int  checks = 0;
  int  idx_m  = 0;

  // Scoreboard: every write strobe and frame pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (mem_we) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected got addr=%0d data=%02h, required no write", mem_addr, mem_din);
      end else begin
        mon_w = wq.pop_front();
        if ({mem_addr, mem_din} !== {mon_w.addr, mon_w.data}) begin
          errors++;
          $display("FAIL write got addr=%0d data=%02h, required addr=%0d data=%02h",
                   mem_addr, mem_din, mon_w.addr, mon_w.data);
        end
      end
    end
    if (frame_done) begin
      checks++;
      if (fq.size() == 0) begin
        errors++;
        $display("FAIL frame_unexpected got count=%0d err=%0b ovf=%0b, required none",
                 byte_count, error, overflow);
      end else begin
        mon_f = fq.pop_front();
        if ({byte_count, error, overflow} !== {mon_f.cnt, mon_f.err, mon_f.ovf}) begin
          errors++;
          $display("FAIL frame got count=%0d err=%0b ovf=%0b, required count=%0d err=%0b ovf=%0b",
                   byte_count, error, overflow, mon_f.cnt, mon_f.err, mon_f.ovf);
        end
      end
    end
  end

  task automatic send_pulse(input int high_len, input int low_len);
    din = 1'b1;
    repeat (high_len) @(negedge clk);
    din = 1'b0;
    repeat (low_len) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    if (b) send_pulse(ONE_HIGH_TIME, TOTAL_PULSE_TIME - ONE_HIGH_TIME);
    else   send_pulse(ZERO_HIGH_TIME, TOTAL_PULSE_TIME - ZERO_HIGH_TIME);
  endtask

  task automatic push_write(input logic [7:0] d);
    wr_t w;
    if (idx_m < MAXB) begin
      w.addr = AW'(idx_m);
      w.data = d;
      wq.push_back(w);
    end
    idx_m++;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic expect_it);
    if (expect_it) push_write(d);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
  endtask

  task automatic expect_frame(input int cnt, input logic err, input logic ovf);
    fr_t f;
    f.cnt = 16'(cnt);
    f.err = err;
    f.ovf = ovf;
    fq.push_back(f);
  endtask

  task automatic gap(input int n);
    din = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    din   = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if ({mem_we, mem_addr, mem_din, frame_done, byte_count, error, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got we=%0b addr=%0d din=%02h fd=%0b cnt=%0d err=%0b ovf=%0b, required all 0",
               mem_we, mem_addr, mem_din, frame_done, byte_count, error, overflow);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_frame();
    gap(GAP);
    idx_m = 0;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    expect_frame(2, 1'b0, 1'b0);
    gap(GAP);
    checks++;
    if (wq.size() != 0 || fq.size() != 0) begin
      errors++;
      $display("FAIL basic_drain got pending writes=%0d frames=%0d, required 0 0", wq.size(), fq.size());
    end
    checks++;
    if (byte_count !== 16'd2) begin
      errors++;
      $display("FAIL basic_count_hold got %0d, required 2", byte_count);
    end
  endtask

  task automatic test_threshold();
    idx_m = 0;
    push_write(8'h6A);
    send_pulse(34, 36);
    send_pulse(35, 35);
    for (int i = 5; i >= 0; i--) send_bit(i[0] == 1'b1);
    push_write(8'h80);
    send_pulse(100, 20);
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    expect_frame(2, 1'b0, 1'b0);
    gap(GAP);
    // Overlong high pulse: error, no write, no frame pulse.
    idx_m = 0;
    send_bit(1'b1);
    send_pulse(101, 50);
    gap(GAP);
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL long_high_error got %0b, required 1", error);
    end
    checks++;
    if (wq.size() != 0 || fq.size() != 0) begin
      errors++;
      $display("FAIL threshold_drain got pending writes=%0d frames=%0d, required 0 0", wq.size(), fq.size());
    end
    idx_m = 0;
    send_byte(8'h5A, 1'b1);
    expect_frame(1, 1'b0, 1'b0);
    gap(GAP);
    checks++;
    if (error !== 1'b0 || wq.size() != 0 || fq.size() != 0) begin
      errors++;
      $display("FAIL recovery got err=%0b writes=%0d frames=%0d, required 0 0 0", error, wq.size(), fq.size());
    end
  endtask

  task automatic test_partial_byte();
    idx_m = 0;
    send_byte(8'hC3, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(i[0] == 1'b0);
    expect_frame(1, 1'b1, 1'b0);
    gap(GAP);
    checks++;
    if (wq.size() != 0 || fq.size() != 0) begin
      errors++;
      $display("FAIL partial_drain got pending writes=%0d frames=%0d, required 0 0", wq.size(), fq.size());
    end
  endtask

  task automatic test_overflow();
    idx_m = 0;
    for (int i = 0; i < MAXB + 2; i++) send_byte(8'(i), 1'b1);
    expect_frame(MAXB + 2, 1'b0, 1'b1);
    gap(GAP);
    idx_m = 0;
    for (int i = 0; i < MAXB; i++) send_byte(8'(8'hF0 + i), 1'b1);
    expect_frame(MAXB, 1'b0, 1'b0);
    gap(GAP);
    checks++;
    if (wq.size() != 0 || fq.size() != 0) begin
      errors++;
      $display("FAIL overflow_drain got pending writes=%0d frames=%0d, required 0 0", wq.size(), fq.size());
    end
  endtask

  task automatic test_glitch();
    logic [7:0] d;
    logic [7:0] exp_byte;
    d = 8'h96;
`ifdef WS2812_DECODER_GLITCH_FILTER_EN
    exp_byte = 8'h96;
`else
    exp_byte = 8'h93;
`endif
    idx_m = 0;
    push_write(exp_byte);
    for (int i = 7; i >= 0; i--) begin
      if (i == 4) begin
        send_pulse(ONE_HIGH_TIME, 8);
        send_pulse(3, 9);
      end else begin
        send_bit(d[i]);
      end
    end
    expect_frame(1, 1'b1, 1'b0);
    gap(GAP);
    checks++;
    if (wq.size() != 0 || fq.size() != 0) begin
      errors++;
      $display("FAIL glitch_drain got pending writes=%0d frames=%0d, required 0 0", wq.size(), fq.size());
    end
  endtask

  task automatic test_mid_frame_reset();
    idx_m = 0;
    send_byte(8'h77, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_we, frame_done, byte_count, error, overflow} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got we=%0b fd=%0b cnt=%0d err=%0b ovf=%0b, required all 0",
               mem_we, frame_done, byte_count, error, overflow);
    end
    @(negedge clk);
    din = 1'b1;
    repeat (30) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    din = 1'b0;
    repeat (20) @(negedge clk);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h00, 1'b0);
    gap(GAP);
    checks++;
    if (wq.size() != 0 || fq.size() != 0) begin
      errors++;
      $display("FAIL midreset_quiet got pending writes=%0d frames=%0d, required 0 0", wq.size(), fq.size());
    end
    idx_m = 0;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    expect_frame(2, 1'b0, 1'b0);
    gap(GAP);
    checks++;
    if (wq.size() != 0 || fq.size() != 0) begin
      errors++;
      $display("FAIL midreset_drain got pending writes=%0d frames=%0d, required 0 0", wq.size(), fq.size());
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_frame();
    test_threshold();
    test_partial_byte();
    test_overflow();
    test_glitch();
    test_mid_frame_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
